// File: rtl/avalon_bouton_pkg.sv
// avalon_bouton_pkg: shared constants for the multi-button Avalon-MM slave.
// Register map, press FSM states and event bit offsets.
`timescale 1ns/1ps
package avalon_bouton_pkg;
  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_EVENT  = 2'd1;
  localparam logic [1:0] REG_LED    = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int EV_LONG_LSB = 16;

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    HELD
  } press_t;
endpackage

// File: rtl/bouton_debounce.sv
// bouton_debounce: 2-FF sync, inversion, tick-based debounce, edge pulses.
// Ports: clk, reset_n, tick, bp (raw, active low) -> level, rise, fall.
`timescale 1ns/1ps
module bouton_debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic bp,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(DEBOUNCE_MS + 1);

  logic [1:0]    sync;
  logic          pressed;
  logic [CW-1:0] cnt;

  assign pressed = ~sync[1];

  // sync resets to 1 so a reset never looks like a press
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync  <= 2'b11;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], bp};
      rise <= 1'b0;
      fall <= 1'b0;
      if (pressed == level) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CW'(DEBOUNCE_MS - 1)) begin
          level <= pressed;
          cnt   <= '0;
          rise  <= pressed;
          fall  <= ~pressed;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/avalon_bouton_multi.sv
// avalon_bouton_multi: N_BP buttons (short/long events), LEDs, beeper over Avalon-MM.
// Ports: clk, reset_n, address, chipselect, write_n, writedata, read_n, readdata,
// bp_i, led_o, out_bip. Macro BIP_TONE_EN: out_bip toggles at BIP_FREQ_HZ in the window.
`timescale 1ns/1ps
module avalon_bouton_multi
  import avalon_bouton_pkg::*;
#(
  parameter int N_BP        = 3,
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int BIP_MS      = 100,
  parameter int BIP_FREQ_HZ = 2000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [1:0]      address,
  input  logic            chipselect,
  input  logic            write_n,
  input  logic [31:0]     writedata,
  input  logic            read_n,
  output logic [31:0]     readdata,
  input  logic [N_BP-1:0] bp_i,
  output logic [N_BP-1:0] led_o,
  output logic            out_bip
);
  localparam int DIV = (CLK_FREQ_HZ / 1000 < 1) ? 1 : CLK_FREQ_HZ / 1000;
  localparam int DW  = $clog2(DIV + 1);
  localparam int HW  = $clog2(LONG_MS + 1);
  localparam int BW  = $clog2(BIP_MS + 1);

  logic [DW-1:0]   pre;
  logic            tick;
  logic [N_BP-1:0] level, rise, fall;
  logic [N_BP-1:0] set_short, set_long;
  logic [N_BP-1:0] ev_short, ev_long, led;
  logic            bip_on_evt;
  logic [BW-1:0]   bip_cnt;
  logic            bip_act, trig;
  logic [31:0]     rdata;
  logic            wr, rd;
  logic            wr_event, wr_led, wr_ctrl;
  logic            unused_wd;
  press_t          st   [N_BP];
  logic [HW-1:0]   hold [N_BP];

  assign unused_wd = ^writedata;

  assign tick = (pre == DW'(DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + 1'b1;
  end

  for (genvar g = 0; g < N_BP; g++) begin : g_db
    bouton_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick),
      .bp      (bp_i[g]),
      .level   (level[g]),
      .rise    (rise[g]),
      .fall    (fall[g])
    );
  end

  // a fall wins over reaching LONG_MS in the same cycle
  always_comb begin
    set_short = '0;
    set_long  = '0;
    for (int i = 0; i < N_BP; i++) begin
      set_short[i] = (st[i] == PRESSED) && fall[i];
      set_long[i]  = (st[i] == PRESSED) && !fall[i] && tick
                     && (hold[i] == HW'(LONG_MS - 1));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_BP; i++) begin
        st[i]   <= IDLE;
        hold[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BP; i++) begin
        unique case (st[i])
          IDLE: if (rise[i]) begin
            st[i]   <= PRESSED;
            hold[i] <= '0;
          end
          PRESSED: if (fall[i]) begin
            st[i] <= IDLE;
          end else if (tick) begin
            hold[i] <= hold[i] + 1'b1;
            if (hold[i] == HW'(LONG_MS - 1)) st[i] <= HELD;
          end
          HELD: if (fall[i]) st[i] <= IDLE;
          default: st[i] <= IDLE;
        endcase
      end
    end
  end

  assign wr       = chipselect & ~write_n;
  assign rd       = chipselect & ~read_n;
  assign wr_event = wr && (address == REG_EVENT);
  assign wr_led   = wr && (address == REG_LED);
  assign wr_ctrl  = wr && (address == REG_CTRL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ev_short   <= '0;
      ev_long    <= '0;
      led        <= '0;
      bip_on_evt <= 1'b0;
    end else begin
      ev_short <= (ev_short & ~(wr_event ? writedata[N_BP-1:0] : '0))
                  | set_short;
      ev_long  <= (ev_long & ~(wr_event ? writedata[EV_LONG_LSB +: N_BP] : '0))
                  | set_long;
      if (wr_led)  led        <= writedata[N_BP-1:0];
      if (wr_ctrl) bip_on_evt <= writedata[0];
    end
  end

  always_comb begin
    rdata = '0;
    unique case (address)
      REG_STATUS: rdata[N_BP-1:0] = level;
      REG_EVENT: begin
        rdata[N_BP-1:0]           = ev_short;
        rdata[EV_LONG_LSB +: N_BP] = ev_long;
      end
      REG_LED:  rdata[N_BP-1:0] = led;
      REG_CTRL: rdata[0]        = bip_on_evt;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else if (rd)  readdata <= rdata;
  end

  assign led_o = led;

  assign trig = (wr_ctrl & writedata[1])
              | (bip_on_evt & (|{set_short, set_long}));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   bip_cnt <= '0;
    else if (trig)                  bip_cnt <= BW'(BIP_MS);
    else if (tick && bip_cnt != '0) bip_cnt <= bip_cnt - 1'b1;
  end

  assign bip_act = (bip_cnt != '0);

`ifdef BIP_TONE_EN
  localparam int HALF_R = CLK_FREQ_HZ / (2 * BIP_FREQ_HZ);
  localparam int HALF   = (HALF_R < 1) ? 1 : HALF_R;
  localparam int TW     = $clog2(HALF + 1);

  logic [TW-1:0] tone_cnt;
  logic          tone;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tone_cnt <= '0;
      tone     <= 1'b1;
    end else if (!bip_act) begin
      tone_cnt <= '0;
      tone     <= 1'b1;
    end else if (tone_cnt == TW'(HALF - 1)) begin
      tone_cnt <= '0;
      tone     <= ~tone;
    end else begin
      tone_cnt <= tone_cnt + 1'b1;
    end
  end

  assign out_bip = bip_act & tone;
`else
  localparam int unused_tone_hz = BIP_FREQ_HZ;
  assign out_bip = bip_act;
`endif
endmodule

// File: tb/tb_avalon_bouton_multi.sv
// tb_avalon_bouton_multi: scoreboard bench for avalon_bouton_multi.
// Directed scenarios plus randomized concurrent presses against a press-length model.
`timescale 1ns/1ps
module tb_avalon_bouton_multi;
  import avalon_bouton_pkg::*;

  localparam int DB   = 4;
  localparam int LNG  = 20;
  localparam int BIPN = 5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic        read_n;
  logic [31:0] readdata;
  logic [2:0]  bp_i;
  logic [2:0]  led_o;
  logic        out_bip;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rd_q = 1'b0;

  logic [2:0] m_short, m_long, m_led;

  int  lens [3];
  int  strt [3];
  bit  act  [3];

  avalon_bouton_multi #(
    .N_BP(3), .CLK_FREQ_HZ(1000), .DEBOUNCE_MS(DB),
    .LONG_MS(LNG), .BIP_MS(BIPN), .BIP_FREQ_HZ(2000)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .read_n     (read_n),
    .readdata   (readdata),
    .bp_i       (bp_i),
    .led_o      (led_o),
    .out_bip    (out_bip)
  );

  always #5 clk = ~clk;

  task automatic check(string nm, logic [31:0] act_v, logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", nm, act_v, exp_v);
    end
  endtask

  always @(posedge clk) rd_q <= chipselect && !read_n && reset_n;

  always @(negedge clk) begin
    if (rd_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_read: got %08h expected nothing", readdata);
      end else begin
        check(name_q.pop_front(), readdata, exp_q.pop_front());
      end
    end
  end

  function automatic logic [31:0] ev_word();
    return (32'(m_long) << EV_LONG_LSB) | 32'(m_short);
  endfunction

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(logic [1:0] a, logic [31:0] e, string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic wait_bip(string nm, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (out_bip) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) check(nm, 32'(out_bip), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit ok;
    logic [31:0] v;
    reset_n = 1'b0; bp_i = 3'b111; chipselect = 1'b0;
    write_n = 1'b1; read_n = 1'b1; address = '0; writedata = '0;
    m_short = '0; m_long = '0; m_led = '0;
    #1;
    check("reset_readdata", readdata, 32'd0);
    check("reset_led", 32'(led_o), 32'd0);
    check("reset_bip", 32'(out_bip), 32'd0);
    cycles(3);
    reset_n = 1'b1;
    cycles(2);
    rd(REG_STATUS, 32'd0, "status_idle");
    rd(REG_EVENT, 32'd0, "event_idle");
    rd(REG_CTRL, 32'd0, "ctrl_idle");

    // bounce on button 0, then a stable press
    for (int k = 0; k < 10; k++) begin
      bp_i[0] = ((k / 2) % 2 == 0) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    bp_i[0] = 1'b0;
    cycles(4);
    rd(REG_STATUS, 32'd0, "status_bounce_early");
    cycles(1);
    rd(REG_STATUS, 32'd1, "status_bounce_late");
    rd(REG_EVENT, 32'd0, "no_event_while_held");
    bp_i[0] = 1'b1;
    cycles(10);
    m_short[0] = 1'b1;
    rd(REG_EVENT, ev_word(), "bounce_short_evt");
    wr(REG_EVENT, 32'h1);
    m_short[0] = 1'b0;

    // short press on button 1
    bp_i[1] = 1'b0;
    cycles(10);
    bp_i[1] = 1'b1;
    cycles(10);
    m_short[1] = 1'b1;
    rd(REG_EVENT, ev_word(), "short_press_evt");
    wr(REG_EVENT, 32'h2);
    m_short[1] = 1'b0;
    rd(REG_EVENT, ev_word(), "short_w1c");

    // long press on button 2, cleared while still held
    bp_i[2] = 1'b0;
    cycles(15);
    rd(REG_EVENT, 32'd0, "long_not_yet");
    cycles(13);
    m_long[2] = 1'b1;
    rd(REG_EVENT, ev_word(), "long_press_evt");
    wr(REG_EVENT, 32'h0004_0000);
    m_long[2] = 1'b0;
    cycles(8);
    bp_i[2] = 1'b1;
    cycles(10);
    rd(REG_EVENT, ev_word(), "long_once_no_short");

    // bip on event
    wr(REG_CTRL, 32'h1);
    bp_i[0] = 1'b0;
    cycles(8);
    bp_i[0] = 1'b1;
    wait_bip("bip1_start", ok);
    if (ok) begin
      n = 0;
      for (int k = 0; k < 20 && out_bip; k++) begin
        n++;
        @(negedge clk);
      end
      check("bip1_len", 32'(n), 32'(BIPN));
    end
    wr(REG_EVENT, 32'h1);

    // retrigger by CTRL write on the third bip cycle
    bp_i[0] = 1'b0;
    cycles(8);
    bp_i[0] = 1'b1;
    wait_bip("bip2_start", ok);
    if (ok) begin
      n = 1;
      @(negedge clk);
      if (out_bip) n++;
      @(negedge clk);
      if (out_bip) n++;
      wr(REG_CTRL, 32'h3);
      for (int k = 0; k < 20 && out_bip; k++) begin
        n++;
        @(negedge clk);
      end
      check("bip2_retrigger_len", 32'(n), 32'(3 + BIPN));
    end
    rd(REG_CTRL, 32'd1, "ctrl_bit1_selfclear");
    wr(REG_EVENT, 32'h1);
    wr(REG_CTRL, 32'h0);

    // W1C lands on the cycle the short event of button 0 is set
    bp_i[0] = 1'b0;
    cycles(8);
    bp_i[0] = 1'b1;
    cycles(2 + DB);
    wr(REG_EVENT, 32'h1);
    cycles(2);
    m_short[0] = 1'b1;
    rd(REG_EVENT, ev_word(), "collision_set_wins");
    wr(REG_EVENT, 32'h1);
    m_short[0] = 1'b0;

    // LED and read-only STATUS
    wr(REG_LED, 32'h5);
    m_led = 3'b101;
    check("led_out", 32'(led_o), 32'(m_led));
    rd(REG_LED, 32'(m_led), "led_read");
    wr(REG_STATUS, 32'hFFFF_FFFF);
    rd(REG_STATUS, 32'd0, "status_write_ignored");
    rd(REG_EVENT, ev_word(), "event_after_status_wr");

    // randomized concurrent presses
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 3; i++) begin
        act[i]  = ($urandom_range(0, 3) != 0);
        lens[i] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(6, 14))
                                             : int'($urandom_range(28, 36));
        strt[i] = int'($urandom_range(0, 6));
      end
      for (int c = 0; c < 46; c++) begin
        for (int i = 0; i < 3; i++)
          bp_i[i] = !(act[i] && c >= strt[i] && c < strt[i] + lens[i]);
        @(negedge clk);
      end
      bp_i = 3'b111;
      cycles(10);
      for (int i = 0; i < 3; i++) begin
        if (act[i]) begin
          if (lens[i] < LNG) m_short[i] = 1'b1;
          else               m_long[i]  = 1'b1;
        end
      end
      rd(REG_EVENT, ev_word(), $sformatf("rand_evt_%0d", r));
      v = $urandom;
      wr(REG_EVENT, v);
      m_short = m_short & ~v[2:0];
      m_long  = m_long & ~v[18:16];
      rd(REG_EVENT, ev_word(), $sformatf("rand_w1c_%0d", r));
      v = $urandom;
      wr(REG_LED, v);
      m_led = v[2:0];
      check($sformatf("rand_led_%0d", r), 32'(led_o), 32'(m_led));
    end

    // asynchronous reset mid-press and mid-bip
    wr(REG_LED, 32'h6);
    bp_i[1] = 1'b0;
    wr(REG_CTRL, 32'h2);
    rd(REG_LED, 32'h6, "led_before_reset");
    #2;
    reset_n = 1'b0;
    #1;
    check("midrun_reset_led", 32'(led_o), 32'd0);
    check("midrun_reset_bip", 32'(out_bip), 32'd0);
    check("midrun_reset_rdata", readdata, 32'd0);
    bp_i = 3'b111;
    m_short = '0; m_long = '0; m_led = '0;
    cycles(2);
    reset_n = 1'b1;
    cycles(2);
    rd(REG_EVENT, ev_word(), "event_after_reset");
    rd(REG_LED, 32'(m_led), "led_after_reset");
    rd(REG_CTRL, 32'd0, "ctrl_after_reset");
    rd(REG_STATUS, 32'd0, "status_after_reset");
    cycles(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
